// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package mult_pkg;

    localparam int MULT_MAX_N = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Ceiling log2 usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-add step: the high accumulator half plus the multiplicand when the
// current multiplier bit is set, producing an (N+1)-bit {carry,sum}.
module mult_step
    import mult_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] acc_hi,
    input  logic [N-1:0] mcand,
    input  logic         mplier_lsb,
    output logic [N:0]   carry_sum
);

    // Conditional add of the multiplicand into the upper accumulator half.
    always_comb begin
        carry_sum = {1'b0, acc_hi};
        if (mplier_lsb) begin
            carry_sum = {1'b0, acc_hi} + {1'b0, mcand};
        end else begin
            carry_sum = {1'b0, acc_hi};
        end
    end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Iterative N-bit shift-add multiplier with valid/ready on both sides.
// Optional two's complement operands when SIGNED_MUL_EN is defined.
module seq_shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = clog2(N + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
`ifdef SIGNED_MUL_EN
    input  logic           is_signed,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] p,
    output logic           busy
);

    localparam int PW = 2 * N;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    if (N < 2 || N > MULT_MAX_N) begin : g_bad_n
        $error("seq_shift_add_multiplier: N out of range");
    end

    mult_state_t    state_q,     state_d;
    logic [N-1:0]   acc_q,       acc_d;
    logic [N-1:0]   mcand_q,     mcand_d;
    logic [N-1:0]   mplier_q,    mplier_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic           in_ready_q,  in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           busy_q,      busy_d;
    logic           sign_q,      sign_d;

    logic [N:0]     step_s;
    logic [PW-1:0]  prod_s;
    logic [PW-1:0]  res_s;
    logic [N-1:0]   a_mag_s;
    logic [N-1:0]   b_mag_s;
    logic           sign_in_s;

    mult_step #(.N(N)) u_step (
        .acc_hi     (acc_q),
        .mcand      (mcand_q),
        .mplier_lsb (mplier_q[0]),
        .carry_sum  (step_s)
    );

    // Operand magnitudes and product sign; in unsigned builds operands pass through.
    always_comb begin
`ifdef SIGNED_MUL_EN
        a_mag_s   = (is_signed && a[N-1]) ? (~a + N'(1)) : a;
        b_mag_s   = (is_signed && b[N-1]) ? (~b + N'(1)) : b;
        sign_in_s = is_signed && (a[N-1] ^ b[N-1]);
`else
        a_mag_s   = a;
        b_mag_s   = b;
        sign_in_s = 1'b0;
`endif
    end

    // Shifted {acc,mplier} after this step, negated on the final step if the sign flag is set.
    always_comb begin
        prod_s = {step_s, mplier_q[N-1:1]};
`ifdef SIGNED_MUL_EN
        if (sign_q) begin
            res_s = ~prod_s + PW'(1);
        end else begin
            res_s = prod_s;
        end
`else
        res_s = prod_s;
`endif
    end

    // Next-state logic for the FSM, datapath registers and handshake outputs.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        sign_d      = sign_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    mcand_d    = a_mag_s;
                    mplier_d   = b_mag_s;
                    sign_d     = sign_in_s;
                    acc_d      = {N{1'b0}};
                    cnt_d      = {CNT_W{1'b0}};
                    state_d    = CALC;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    {acc_d, mplier_d} = res_s;
                    state_d           = DONE;
                    out_valid_d       = 1'b1;
                end else begin
                    {acc_d, mplier_d} = prod_s;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State registers; reset abandons any product in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= {N{1'b0}};
            mcand_q     <= {N{1'b0}};
            mplier_q    <= {N{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sign_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            sign_q      <= sign_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign p         = {acc_q, mplier_q};

endmodule
